// File: rtl/fast_square_sample_packer.sv
// I/Q sample packer: FIFO of I/Q pairs with record marker,
// overrun accounting and a two-word serializer for the USB RX path.
module fast_square_sample_packer #(
  parameter int DEPTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    record,
  input  logic                    in_strobe,
  input  logic [15:0]             i_in,
  input  logic [15:0]             q_in,
  output logic [15:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic [15:0]             dropped_count,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [31:0] MARKER = 32'h7FFF_7FFF;

  typedef enum logic [1:0] {
    IDLE,
    SEND_I,
    SEND_Q
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          rec_q;
  logic          rec_rise;
  logic          full;
  logic          take;
  logic          push;
  logic          drop;
  logic          pop;
  logic [LW-1:0] level_nxt;
  logic [31:0]   push_data;

  // The marker wins over a coincident strobe; that sample is lost.
  always_comb begin
    rec_rise  = record & ~rec_q;
    full      = (fifo_level == LW'(DEPTH));
    take      = record & in_strobe & ~rec_rise;
    push      = (rec_rise | take) & ~full;
    drop      = take & full;
    push_data = rec_rise ? MARKER : {i_in, q_in};
    pop       = (state == SEND_Q) & out_ready;
    rd_nxt    = rd_ptr + AW'(1);
    level_nxt = fifo_level;
    unique case ({push, pop})
      2'b10:   level_nxt = fifo_level + LW'(1);
      2'b01:   level_nxt = fifo_level - LW'(1);
      default: level_nxt = fifo_level;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_data      <= 16'h0000;
      overrun       <= 1'b0;
      dropped_count <= 16'h0000;
      fifo_level    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rec_q         <= 1'b0;
    end else begin
      rec_q      <= record;
      fifo_level <= level_nxt;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_nxt;

      if (rec_rise) begin
        overrun       <= 1'b0;
        dropped_count <= 16'h0000;
      end else if (drop) begin
        overrun <= 1'b1;
        if (dropped_count != 16'hFFFF)
          dropped_count <= dropped_count + 16'd1;
      end

      unique case (state)
        IDLE: begin
          if (fifo_level != '0) begin
            state     <= SEND_I;
            out_valid <= 1'b1;
            out_data  <= mem[rd_ptr][31:16];
          end
        end
        SEND_I: begin
          if (out_ready) begin
            state    <= SEND_Q;
            out_data <= mem[rd_ptr][15:0];
          end
        end
        SEND_Q: begin
          if (out_ready) begin
            // Chain straight into the next pair to keep 2 cycles/pair.
            if (fifo_level > LW'(1)) begin
              state    <= SEND_I;
              out_data <= mem[rd_nxt][31:16];
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fast_square_sample_packer.sv
// Bench for fast_square_sample_packer: queue-based reference
// model plus directed and randomized scenarios.
module tb_fast_square_sample_packer;

  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          record;
  logic          in_strobe;
  logic [15:0]   i_in;
  logic [15:0]   q_in;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic [15:0]   dropped_count;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  logic [15:0] got[$];
  bit          m_rec;
  bit          m_ovr;
  int          m_drop;
  bit          m_phase;

  always #5 clock = ~clock;

  fast_square_sample_packer #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .record(record),
    .in_strobe(in_strobe),
    .i_in(i_in),
    .q_in(q_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun),
    .dropped_count(dropped_count),
    .fifo_level(fifo_level)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // At each falling edge: compare DUT to model, then apply
  // what the coming rising edge will do to the model.
  task automatic scoreboard();
    bit          rise;
    bit          full;
    logic [15:0] exp;
    forever begin
      @(negedge clock);
      if (reset) begin
        mq.delete();
        m_rec = 0;
        m_ovr = 0;
        m_drop = 0;
        m_phase = 0;
      end
      checks++;
      if (fifo_level !== LW'(mq.size()) || overrun !== m_ovr ||
          dropped_count !== 16'(m_drop)) begin
        errors++;
        $display("FAIL sb_state: level=%0d ovr=%b drop=%0d, want %0d %b %0d",
                 fifo_level, overrun, dropped_count,
                 mq.size(), m_ovr, m_drop);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL sb_spurious: out_data=%h valid with empty model",
                   out_data);
        end else begin
          exp = m_phase ? mq[0][15:0] : mq[0][31:16];
          if (out_data !== exp) begin
            errors++;
            $display("FAIL sb_word: out_data=%h, want %h", out_data, exp);
          end
        end
      end
      if (!reset) begin
        rise = record && !m_rec;
        full = (mq.size() == DEPTH);
        if (rise) begin
          if (!full) mq.push_back(32'h7FFF7FFF);
          m_ovr = 0;
          m_drop = 0;
        end else if (record && in_strobe) begin
          if (full) begin
            m_ovr = 1;
            if (m_drop < 65535) m_drop++;
          end else begin
            mq.push_back({i_in, q_in});
          end
        end
        if (out_valid && out_ready && mq.size() > 0) begin
          got.push_back(out_data);
          if (m_phase) void'(mq.pop_front());
          m_phase = !m_phase;
        end
        m_rec = record;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h, want 0 0000",
               out_valid, out_data);
    end
    checks++;
    if (overrun !== 1'b0 || dropped_count !== 16'h0 ||
        fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_flags: ovr=%b drop=%0d lvl=%0d, want 0 0 0",
               overrun, dropped_count, fifo_level);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_marker_pair();
    logic [15:0] exp4 [4];
    int base;
    exp4[0] = 16'h7FFF;
    exp4[1] = 16'h7FFF;
    exp4[2] = 16'h1234;
    exp4[3] = 16'hABCD;
    base = got.size();
    out_ready = 1'b1;
    record = 1'b1;
    tick();
    checks++;
    if (fifo_level !== LW'(1) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_e1: lvl=%0d valid=%b, want 1 0",
               fifo_level, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h7FFF) begin
      errors++;
      $display("FAIL latency_e2: valid=%b data=%h, want 1 7fff",
               out_valid, out_data);
    end
    i_in = 16'h1234;
    q_in = 16'hABCD;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (got.size() >= base + 4 && fifo_level == '0) break;
      tick();
    end
    checks++;
    if (got.size() != base + 4) begin
      errors++;
      $display("FAIL marker_count: words=%0d, want 4", got.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[base+k] !== exp4[k]) begin
          errors++;
          $display("FAIL marker_word%0d: got %h, want %h",
                   k, got[base+k], exp4[k]);
        end
      end
    end
    checks++;
    if (fifo_level !== '0) begin
      errors++;
      $display("FAIL marker_level: lvl=%0d, want 0", fifo_level);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    i_in = 16'h0042;
    q_in = 16'h5555;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid === 1'b1) break;
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0042) begin
      errors++;
      $display("FAIL bp_start: valid=%b data=%h, want 1 0042",
               out_valid, out_data);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0042) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h, want 1 0042",
                 n, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h5555) begin
      errors++;
      $display("FAIL bp_q: valid=%b data=%h, want 1 5555",
               out_valid, out_data);
    end
    tick();
    checks++;
    if (fifo_level !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: lvl=%0d valid=%b, want 0 0",
               fifo_level, out_valid);
    end
  endtask

  task automatic test_throughput();
    int base;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_in = 16'($urandom);
      q_in = 16'($urandom);
      in_strobe = 1'b1;
      tick();
    end
    in_strobe = 1'b0;
    tick();
    checks++;
    if (fifo_level !== LW'(4) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL tp_fill: lvl=%0d valid=%b, want 4 1",
               fifo_level, out_valid);
    end
    base = got.size();
    out_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (got.size() != base + 8 || fifo_level !== '0 ||
        out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tp_rate: words=%0d lvl=%0d valid=%b, want 8 0 0",
               got.size() - base, fifo_level, out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_strobe = ($urandom_range(0, 3) == 0);
      i_in = 16'($urandom);
      q_in = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) record = !record;
      tick();
    end
    in_strobe = 1'b0;
    record = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (fifo_level == '0 && out_valid == 1'b0) break;
      tick();
    end
    checks++;
    if (fifo_level !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: lvl=%0d valid=%b, want 0 0",
               fifo_level, out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    record = 1'b0;
    tick();
    record = 1'b1;
    tick();
    for (int n = 0; n < 20; n++) begin
      i_in = 16'($urandom);
      q_in = 16'($urandom);
      in_strobe = 1'b1;
      tick();
    end
    in_strobe = 1'b0;
    tick();
    checks++;
    if (fifo_level !== LW'(16) || dropped_count !== 16'd5 ||
        overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovf: lvl=%0d drop=%0d ovr=%b, want 16 5 1",
               fifo_level, dropped_count, overrun);
    end
    record = 1'b0;
    tick();
    record = 1'b1;
    tick();
    checks++;
    if (dropped_count !== 16'd0 || overrun !== 1'b0 ||
        fifo_level !== LW'(16)) begin
      errors++;
      $display("FAIL ovf_clear: drop=%0d ovr=%b lvl=%0d, want 0 0 16",
               dropped_count, overrun, fifo_level);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_strobe = 1'b1;
    repeat (65534) tick();
    checks++;
    if (dropped_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_pre: drop=%h, want fffe", dropped_count);
    end
    repeat (6) tick();
    in_strobe = 1'b0;
    tick();
    checks++;
    if (dropped_count !== 16'hFFFF || overrun !== 1'b1 ||
        fifo_level !== LW'(16)) begin
      errors++;
      $display("FAIL sat: drop=%h ovr=%b lvl=%0d, want ffff 1 16",
               dropped_count, overrun, fifo_level);
    end
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (fifo_level == '0 && out_valid == 1'b0) break;
      tick();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_in = 16'($urandom);
      q_in = 16'($urandom);
      in_strobe = 1'b1;
      tick();
    end
    in_strobe = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid === 1'b1) break;
      tick();
    end
    checks++;
    if (fifo_level !== LW'(3) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sim_setup: lvl=%0d valid=%b, want 3 1",
               fifo_level, out_valid);
    end
    out_ready = 1'b1;
    tick();
    i_in = 16'($urandom);
    q_in = 16'($urandom);
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (fifo_level !== LW'(3)) begin
      errors++;
      $display("FAIL sim_level: lvl=%0d, want 3", fifo_level);
    end
  endtask

  task automatic test_async_reset();
    int base;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_sendq: valid=%b, want 1", out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== '0 ||
        out_data !== 16'h0000) begin
      errors++;
      $display("FAIL ar_immediate: valid=%b lvl=%0d data=%h, want 0 0 0000",
               out_valid, fifo_level, out_data);
    end
    tick();
    reset = 1'b0;
    base = got.size();
    out_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (got.size() != base + 2) begin
      errors++;
      $display("FAIL ar_words: count=%0d, want 2", got.size() - base);
    end else begin
      checks++;
      if (got[base] !== 16'h7FFF || got[base+1] !== 16'h7FFF) begin
        errors++;
        $display("FAIL ar_marker: got %h %h, want 7fff 7fff",
                 got[base], got[base+1]);
      end
    end
    checks++;
    if (fifo_level !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_idle: lvl=%0d valid=%b, want 0 0",
               fifo_level, out_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    record = 1'b0;
    in_strobe = 1'b0;
    i_in = 16'h0;
    q_in = 16'h0;
    out_ready = 1'b0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_marker_pair();
    test_backpressure();
    test_throughput();
    test_random();
    test_overflow();
    test_saturation();
    test_simul_push_pop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
